// File: rtl/slc3_mem_io_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : slc3_mem_io_ctrl
//  Description : Memory / IO bus sequencer for the SLC-3. Turns the control
//                unit's active-low Mem_CE/Mem_OE/Mem_WE strobes into timed
//                asynchronous-SRAM read and write cycles with configurable
//                wait states. One address is decoded as memory-mapped IO:
//                reads return the board switches, writes load the hex
//                display register.
//  Revision    : 1.0 - initial release
// ============================================================================
module slc3_mem_io_ctrl #(
    parameter int          WAIT_CYCLES = 1,        // extra strobe cycles, 0..7
    parameter logic [15:0] IO_ADDR     = 16'hFFFF  // memory-mapped IO address
) (
    input  logic        Clk,
    input  logic        Reset,      // asynchronous, active-low
    input  logic        Mem_CE,
    input  logic        Mem_OE,
    input  logic        Mem_WE,
    input  logic [15:0] MAR,
    input  logic [15:0] MDR_in,
    input  logic [15:0] Switches,
    input  logic [15:0] DQ_in,
    output logic [15:0] Rd_data,
    output logic        Rd_valid,
    output logic        Busy,
    output logic        Conflict,
    output logic [15:0] HEX_data,
    output logic [19:0] SRAM_ADDR,
    output logic        SRAM_CE_N,
    output logic        SRAM_OE_N,
    output logic        SRAM_WE_N,
    output logic        SRAM_UB_N,
    output logic        SRAM_LB_N,
    output logic [15:0] DQ_out,
    output logic        DQ_oe
);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_RD       = 3'd1,
        S_RD_CAP   = 3'd2,
        S_WR_SETUP = 3'd3,
        S_WR_PULSE = 3'd4,
        S_WR_HOLD  = 3'd5,
        S_IO_RD    = 3'd6,
        S_DONE     = 3'd7
    } state_t;

    // Wait counter reload value; strobe phases last C_WAIT_INIT+1 cycles.
    localparam logic [2:0] C_WAIT_INIT = WAIT_CYCLES[2:0];

    state_t      state_q,    state_d;
    logic [2:0]  wait_q,     wait_d;
    logic [15:0] addr_q,     addr_d;
    logic [15:0] data_q,     data_d;
    logic [15:0] hex_q,      hex_d;
    logic [15:0] rd_data_q,  rd_data_d;
    logic        rd_valid_q, rd_valid_d;
    logic        conflict_q, conflict_d;
    logic        ce_n_q,     ce_n_d;
    logic        oe_n_q,     oe_n_d;
    logic        we_n_q,     we_n_d;
    logic        dq_oe_q,    dq_oe_d;

    logic        w_req_rd;
    logic        w_req_wr;
    logic        w_accept;
    logic        w_is_io;

    assign w_req_rd = ~Mem_OE;
    assign w_req_wr = ~Mem_WE;
    assign w_accept = ~Mem_CE & (w_req_rd | w_req_wr);
    assign w_is_io  = (MAR == IO_ADDR);

    // Next-state, latching of the request, and read/IO data capture.
    always_comb begin
        state_d    = state_q;
        wait_d     = wait_q;
        addr_d     = addr_q;
        data_d     = data_q;
        hex_d      = hex_q;
        rd_data_d  = rd_data_q;
        rd_valid_d = 1'b0;
        conflict_d = conflict_q;

        case (state_q)
            S_IDLE: begin
                if (w_accept) begin
                    // Address and data are frozen here for the whole access.
                    addr_d = MAR;
                    data_d = MDR_in;
                    wait_d = C_WAIT_INIT;
                    if (w_req_rd && w_req_wr) begin
                        conflict_d = 1'b1;
                    end
                    if (w_req_wr) begin
                        // Write takes priority over a simultaneous read.
                        if (w_is_io) begin
                            hex_d   = MDR_in;
                            state_d = S_DONE;
                        end else begin
                            state_d = S_WR_SETUP;
                        end
                    end else begin
                        state_d = w_is_io ? S_IO_RD : S_RD;
                    end
                end
            end
            S_RD: begin
                if (wait_q == 3'd0) begin
                    state_d = S_RD_CAP;
                end else begin
                    wait_d = wait_q - 3'd1;
                end
            end
            S_RD_CAP: begin
                // Strobes are still low here, so DQ_in is stable to sample.
                rd_data_d  = DQ_in;
                rd_valid_d = 1'b1;
                state_d    = S_DONE;
            end
            S_WR_SETUP: begin
                wait_d  = C_WAIT_INIT;
                state_d = S_WR_PULSE;
            end
            S_WR_PULSE: begin
                if (wait_q == 3'd0) begin
                    state_d = S_WR_HOLD;
                end else begin
                    wait_d = wait_q - 3'd1;
                end
            end
            S_WR_HOLD: begin
                state_d = S_DONE;
            end
            S_IO_RD: begin
                rd_data_d  = Switches;
                rd_valid_d = 1'b1;
                state_d    = S_DONE;
            end
            S_DONE: begin
                // Wait for the control unit to drop its strobes so a held
                // strobe cannot retrigger the same access.
                if (Mem_OE && Mem_WE) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // SRAM strobes decoded from the next state so the registered copies
    // line up exactly with the state they belong to.
    always_comb begin
        ce_n_d  = 1'b1;
        oe_n_d  = 1'b1;
        we_n_d  = 1'b1;
        dq_oe_d = 1'b0;
        case (state_d)
            S_RD, S_RD_CAP: begin
                ce_n_d = 1'b0;
                oe_n_d = 1'b0;
            end
            S_WR_SETUP, S_WR_HOLD: begin
                ce_n_d  = 1'b0;
                dq_oe_d = 1'b1;
            end
            S_WR_PULSE: begin
                ce_n_d  = 1'b0;
                we_n_d  = 1'b0;
                dq_oe_d = 1'b1;
            end
            default: begin
                ce_n_d = 1'b1;
            end
        endcase
    end

    // State and output registers; reset drops every strobe immediately.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q    <= S_IDLE;
            wait_q     <= 3'd0;
            addr_q     <= 16'h0000;
            data_q     <= 16'h0000;
            hex_q      <= 16'h0000;
            rd_data_q  <= 16'h0000;
            rd_valid_q <= 1'b0;
            conflict_q <= 1'b0;
            ce_n_q     <= 1'b1;
            oe_n_q     <= 1'b1;
            we_n_q     <= 1'b1;
            dq_oe_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            wait_q     <= wait_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
            hex_q      <= hex_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
            conflict_q <= conflict_d;
            ce_n_q     <= ce_n_d;
            oe_n_q     <= oe_n_d;
            we_n_q     <= we_n_d;
            dq_oe_q    <= dq_oe_d;
        end
    end

    assign Rd_data   = rd_data_q;
    assign Rd_valid  = rd_valid_q;
    assign Busy      = (state_q != S_IDLE);
    assign Conflict  = conflict_q;
    assign HEX_data  = hex_q;
    assign SRAM_ADDR = {4'h0, addr_q};
    assign SRAM_CE_N = ce_n_q;
    assign SRAM_OE_N = oe_n_q;
    assign SRAM_WE_N = we_n_q;
    // Always 16-bit accesses, so both byte lanes follow chip enable.
    assign SRAM_UB_N = ce_n_q;
    assign SRAM_LB_N = ce_n_q;
    assign DQ_out    = data_q;
    assign DQ_oe     = dq_oe_q;

endmodule
`default_nettype wire

// File: tb/tb_slc3_mem_io_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_slc3_mem_io_ctrl
//  Description : Directed self-checking bench for slc3_mem_io_ctrl with a
//                small behavioural SRAM attached to the data bus.
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_slc3_mem_io_ctrl;

    logic        Clk;
    logic        Reset;
    logic        Mem_CE, Mem_OE, Mem_WE;
    logic [15:0] MAR, MDR_in, Switches, DQ_in;
    logic [15:0] Rd_data, HEX_data, DQ_out;
    logic        Rd_valid, Busy, Conflict, DQ_oe;
    logic [19:0] SRAM_ADDR;
    logic        SRAM_CE_N, SRAM_OE_N, SRAM_WE_N, SRAM_UB_N, SRAM_LB_N;

    int n_chk  = 0;
    int n_pass = 0;

    slc3_mem_io_ctrl #(.WAIT_CYCLES(1), .IO_ADDR(16'hFFFF)) dut (
        .Clk(Clk), .Reset(Reset),
        .Mem_CE(Mem_CE), .Mem_OE(Mem_OE), .Mem_WE(Mem_WE),
        .MAR(MAR), .MDR_in(MDR_in), .Switches(Switches), .DQ_in(DQ_in),
        .Rd_data(Rd_data), .Rd_valid(Rd_valid), .Busy(Busy),
        .Conflict(Conflict), .HEX_data(HEX_data), .SRAM_ADDR(SRAM_ADDR),
        .SRAM_CE_N(SRAM_CE_N), .SRAM_OE_N(SRAM_OE_N), .SRAM_WE_N(SRAM_WE_N),
        .SRAM_UB_N(SRAM_UB_N), .SRAM_LB_N(SRAM_LB_N),
        .DQ_out(DQ_out), .DQ_oe(DQ_oe)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Behavioural SRAM: 1K words, written while CE and WE are both low.
    logic [15:0] mem [0:1023];
    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 16'h0000;
        mem[10'h042] = 16'h1234;
    end
    always @(posedge Clk) begin
        if (!SRAM_CE_N && !SRAM_WE_N) mem[SRAM_ADDR[9:0]] <= DQ_out;
    end
    assign DQ_in = (!SRAM_CE_N && !SRAM_OE_N) ? mem[SRAM_ADDR[9:0]] : 16'h0000;

    // Bus activity counters and invariant watchers, sampled mid-cycle.
    int   cnt_oe = 0, cnt_we = 0, cnt_ce = 0, cnt_dqoe = 0, cnt_valid = 0;
    int   viol_inv = 0, viol_turn = 0;
    logic prev_dqoe = 1'b0;
    logic [15:0] last_dq_out = 16'h0000;
    always @(negedge Clk) begin
        if (!SRAM_OE_N) cnt_oe++;
        if (!SRAM_WE_N) cnt_we++;
        if (!SRAM_CE_N) cnt_ce++;
        if (DQ_oe) begin
            cnt_dqoe++;
            last_dq_out = DQ_out;
        end
        if (Rd_valid) cnt_valid++;
        if (DQ_oe && !SRAM_OE_N) viol_inv++;
        if (prev_dqoe && !SRAM_OE_N) viol_turn++;
        prev_dqoe = DQ_oe;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    // Issue one request at a negedge. With hold=1 the strobe stays low for
    // several extra cycles to show the sequencer parks in DONE.
    task automatic txn(input logic oe, input logic we, input logic [15:0] mar,
                       input logic [15:0] mdr, input bit hold);
        bit seen;
        seen = 0;
        Mem_CE = 1'b0; Mem_OE = oe; Mem_WE = we; MAR = mar; MDR_in = mdr;
        for (int i = 0; i < 20; i++) begin
            @(negedge Clk);
            if (Busy) begin seen = 1; break; end
        end
        if (!seen) chk("accept_timeout", 32'd0, 32'd1);
        if (hold) begin
            repeat (8) @(negedge Clk);
            chk("busy_while_held", {31'd0, Busy}, 32'd1);
        end
        // Drop the request and scramble the bus: must not affect the access.
        Mem_CE = 1'b1; Mem_OE = 1'b1; Mem_WE = 1'b1;
        MAR = 16'h0055; MDR_in = 16'hDEAD;
        seen = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge Clk);
            if (!Busy) begin seen = 1; break; end
        end
        if (!seen) chk("done_timeout", 32'd0, 32'd1);
    endtask

    int b_oe, b_we, b_ce, b_dq, b_v;
    task automatic snap();
        b_oe = cnt_oe; b_we = cnt_we; b_ce = cnt_ce; b_dq = cnt_dqoe; b_v = cnt_valid;
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin
        Reset = 1'b0; Mem_CE = 1'b1; Mem_OE = 1'b1; Mem_WE = 1'b1;
        MAR = 16'h0000; MDR_in = 16'h0000; Switches = 16'h0000;
        repeat (3) @(negedge Clk);
        chk("rst_strobes", {27'd0, SRAM_CE_N, SRAM_OE_N, SRAM_WE_N, SRAM_UB_N, SRAM_LB_N}, 32'h1F);
        chk("rst_outs", {28'd0, DQ_oe, Rd_valid, Busy, Conflict}, 32'h0);
        chk("rst_data", {Rd_data, HEX_data}, 32'h0);
        chk("rst_addr_dq", {SRAM_ADDR[15:0], DQ_out}, 32'h0);
        Reset = 1'b1;
        @(negedge Clk);

        // Requests ignored while Mem_CE is high.
        Mem_CE = 1'b1; Mem_OE = 1'b0;
        repeat (3) @(negedge Clk);
        chk("ce_high_ignored", {31'd0, Busy}, 32'd0);
        Mem_OE = 1'b1;
        @(negedge Clk);

        // SRAM read of preloaded word, strobe held to exercise DONE.
        snap();
        txn(1'b0, 1'b1, 16'h0042, 16'h0000, 1'b1);
        chk("rd_oe_cycles", cnt_oe - b_oe, 32'd3);
        chk("rd_valid_pulses", cnt_valid - b_v, 32'd1);
        chk("rd_data_1234", {16'd0, Rd_data}, 32'h1234);
        chk("rd_busy_low", {31'd0, Busy}, 32'd0);

        // SRAM write.
        snap();
        txn(1'b1, 1'b0, 16'h0010, 16'hBEEF, 1'b0);
        chk("wr_we_cycles", cnt_we - b_we, 32'd2);
        chk("wr_dqoe_cycles", cnt_dqoe - b_dq, 32'd4);
        chk("wr_ce_cycles", cnt_ce - b_ce, 32'd4);
        chk("wr_dq_out", {16'd0, last_dq_out}, 32'hBEEF);
        chk("wr_mem", {16'd0, mem[10'h010]}, 32'hBEEF);
        chk("wr_no_scramble", {16'd0, mem[10'h055]}, 32'h0);

        // Read back immediately after the write.
        txn(1'b0, 1'b1, 16'h0010, 16'h0000, 1'b0);
        chk("rdback_beef", {16'd0, Rd_data}, 32'hBEEF);
        chk("turnaround", viol_turn, 32'd0);

        // IO read from switches.
        Switches = 16'h00A5;
        snap();
        txn(1'b0, 1'b1, 16'hFFFF, 16'h0000, 1'b0);
        chk("io_rd_data", {16'd0, Rd_data}, 32'h00A5);
        chk("io_rd_ce", cnt_ce - b_ce, 32'd0);
        chk("io_rd_valid", cnt_valid - b_v, 32'd1);

        // IO write to hex display.
        snap();
        txn(1'b1, 1'b0, 16'hFFFF, 16'h1337, 1'b0);
        chk("io_wr_hex", {16'd0, HEX_data}, 32'h1337);
        chk("io_wr_strobes", (cnt_ce - b_ce) + (cnt_we - b_we) + (cnt_dqoe - b_dq), 32'd0);
        chk("io_wr_mem", {mem[10'h3FF], mem[10'h042]}, {16'h0000, 16'h1234});
        chk("rd_data_held", {16'd0, Rd_data}, 32'h00A5);

        // Simultaneous read+write request: write wins, Conflict sticks.
        snap();
        txn(1'b0, 1'b0, 16'h0020, 16'h5A5A, 1'b0);
        chk("conf_mem", {16'd0, mem[10'h020]}, 32'h5A5A);
        chk("conf_flag", {31'd0, Conflict}, 32'd1);
        chk("conf_no_read", cnt_oe - b_oe, 32'd0);
        chk("conf_we_cycles", cnt_we - b_we, 32'd2);
        txn(1'b0, 1'b1, 16'h0042, 16'h0000, 1'b0);
        chk("conf_sticky", {31'd0, Conflict}, 32'd1);
        chk("rd_after_conf", {16'd0, Rd_data}, 32'h1234);

        // Asynchronous reset in the middle of a write pulse.
        Mem_CE = 1'b0; Mem_WE = 1'b0; MAR = 16'h0030; MDR_in = 16'h7777;
        begin
            bit seen;
            seen = 0;
            for (int i = 0; i < 20; i++) begin
                @(negedge Clk);
                if (!SRAM_WE_N) begin seen = 1; break; end
            end
            if (!seen) chk("wr_pulse_timeout", 32'd0, 32'd1);
        end
        chk("pre_rst_we", {30'd0, SRAM_WE_N, DQ_oe}, 32'b01);
        #2 Reset = 1'b0;
        #1;
        chk("async_rst_we_dqoe", {30'd0, SRAM_WE_N, DQ_oe}, 32'b10);
        chk("async_rst_hex", {16'd0, HEX_data}, 32'h0);
        chk("async_rst_conf", {31'd0, Conflict}, 32'd0);
        Mem_CE = 1'b1; Mem_WE = 1'b1;
        @(negedge Clk);
        Reset = 1'b1;
        @(negedge Clk);
        chk("post_rst_idle", {31'd0, Busy}, 32'd0);
        chk("post_rst_rddata", {16'd0, Rd_data}, 32'h0);

        chk("inv_dqoe_oe", viol_inv, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/slc3_mem_io_ctrl.md
Name: slc3_mem_io_ctrl

Overview:
- Memory/IO bus sequencer directly downstream of the SLC-3 control unit.
- Consumes its active-low Mem_CE/Mem_OE/Mem_WE strobes plus MAR and MDR contents.
- Runs timed SRAM read/write cycles with configurable wait states and a registered data-bus direction control.
- Decodes one memory-mapped IO address: a read returns the switches, a write loads the hex-display register.

Parameters:
- WAIT_CYCLES, 1, extra SRAM strobe cycles beyond the first; legal range 0..7.
- IO_ADDR, 16'hFFFF, MAR value decoded as memory-mapped IO.

Ports:
- Clk  in  1  system clock.
- Reset  in  1  asynchronous, active-low reset.
- Mem_CE  in  1  active-low access enable from control unit.
- Mem_OE  in  1  active-low read request.
- Mem_WE  in  1  active-low write request.
- MAR  in  16  access address.
- MDR_in  in  16  write data from CPU.
- Switches  in  16  board switches; IO read source.
- DQ_in  in  16  SRAM data bus, input side.
- Rd_data  out  16  registered read result.
- Rd_valid  out  1  one-cycle pulse when Rd_data updates.
- Busy  out  1  high whenever state is not IDLE.
- Conflict  out  1  sticky flag: OE and WE requested together; cleared only by reset.
- HEX_data  out  16  memory-mapped display register.
- SRAM_ADDR  out  20  {4'h0, latched MAR}.
- SRAM_CE_N, SRAM_OE_N, SRAM_WE_N, SRAM_UB_N, SRAM_LB_N  out  1 each  SRAM strobes, all registered.
- DQ_out  out  16  latched write data.
- DQ_oe  out  1  top-level tristate enable for DQ.

Behaviour:
- Reset low, asynchronous: state goes to IDLE; all SRAM_*_N are 1; DQ_oe=0; Rd_data=0; Rd_valid=0; Busy=0; Conflict=0; HEX_data=0; SRAM_ADDR=0; DQ_out=0. A write in progress aborts and WE_N rises immediately.
- States: IDLE, RD, RD_CAP, WR_SETUP, WR_PULSE, WR_HOLD, IO_RD, DONE.
- IDLE accepts a request when Mem_CE=0 and (Mem_OE=0 or Mem_WE=0).
  - On acceptance, MAR and MDR_in are latched. Later changes to them are ignored until IDLE is re-entered.
  - If Mem_WE=0 and Mem_OE=0 together, the write wins and Conflict is set.
- SRAM read (MAR != IO_ADDR): IDLE -> RD.
  - CE_N=0, OE_N=0, UB_N=0, LB_N=0 for WAIT_CYCLES+1 cycles, timed by a 3-bit wait counter.
  - Then RD_CAP: strobes stay low; Rd_data <= DQ_in; Rd_valid=1 for this cycle only.
  - Then DONE.
- IO read (MAR == IO_ADDR): IDLE -> IO_RD. Rd_data <= Switches; Rd_valid pulses; no SRAM strobe asserts. Then DONE.
- SRAM write (MAR != IO_ADDR), in order:
  - WR_SETUP, 1 cycle: CE_N/UB_N/LB_N=0, WE_N=1, DQ_oe=1.
  - WR_PULSE, WAIT_CYCLES+1 cycles: WE_N=0, DQ_oe=1.
  - WR_HOLD, 1 cycle: WE_N=1, DQ_oe=1.
  - Then DONE.
- IO write: HEX_data <= latched data in the acceptance cycle; no SRAM strobe asserts; go to DONE.
- DONE: all strobes high, DQ_oe=0. Return to IDLE once Mem_OE=1 and Mem_WE=1. This prevents re-triggering while the control unit holds a strobe across several cycles.
- Invariants:
  - DQ_oe=1 and SRAM_OE_N=0 never occur in the same cycle.
  - At least one cycle with both deasserted separates any write from the next read (bus turnaround).
- Mem_CE=1 in IDLE: requests are ignored.
- A request that deasserts mid-access does not abort the access; the sequence runs to DONE.
- Rd_data holds its value until the next read completes.

Test Plan:
- Reset released; bench model stores 0x1234 @0x0042; MAR=0x0042, Mem_OE low -> SRAM_OE_N low for exactly 3 cycles (2 in RD + 1 in RD_CAP), Rd_data=0x1234, Rd_valid is a single-cycle pulse, Busy returns low after Mem_OE rises.
- Write MDR_in=0xBEEF to MAR=0x0010 -> WE_N low exactly 2 cycles; DQ_oe high for 4 cycles framing the pulse; DQ_out=0xBEEF; a subsequent read returns 0xBEEF with a turnaround gap of at least 1 cycle.
- MAR=0xFFFF, Switches=0x00A5, Mem_OE low -> Rd_data=0x00A5; SRAM_CE_N stays 1 throughout.
- MAR=0xFFFF write of 0x1337 -> HEX_data=0x1337; SRAM strobes idle; SRAM contents unchanged.
- Mem_OE and Mem_WE both low at MAR=0x0020 with data 0x5A5A -> write performed, Conflict=1 and stays 1 until reset.
- Reset asserted during WR_PULSE -> SRAM_WE_N and DQ_oe deassert the same instant, without waiting for a clock edge; HEX_data=0; state is IDLE after release.
